// File: rtl/addac_4_if.sv
// Operand/strobe/result bundle for the addac_4 accumulator.
// The master drives operands and the strobe; the slave returns the registered result.
interface addac_4_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic             sel0;
  logic             sel1;
  logic             iclk;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output a, output sel0, output sel1, output iclk,
                  input  s, input  cout);
  modport slave  (input  a, input  sel0, input  sel1, input  iclk,
                  output s, output cout);
endinterface

// File: rtl/addac_4.sv
// Adder/accumulator with carry flag: one LOAD/ADD/SUB/CLEAR per rising edge of the
// slow iclk strobe, sampled in the clk domain; result and carry are registered.
module addac_4 #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  addac_4_if.slave bus
);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             cy_reg, cy_next;
  logic             iclk_q_reg;
  logic             strobe;
  logic [WIDTH-1:0] a_inv;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_inv
      assign a_inv[gi] = ~bus.a[gi];
    end
  endgenerate

  // Subtraction as acc + ~a + 1, so the carry out doubles as the no-borrow flag.
  assign add_sum = {1'b0, acc_reg} + {1'b0, bus.a};
  assign sub_sum = {1'b0, acc_reg} + {1'b0, a_inv} + {{WIDTH{1'b0}}, 1'b1};
  assign strobe  = bus.iclk & ~iclk_q_reg;

  always_comb begin
    acc_next = acc_reg;
    cy_next  = cy_reg;
    if (strobe) begin
      case ({bus.sel1, bus.sel0})
        OP_LOAD: begin
          acc_next = bus.a;
          cy_next  = 1'b0;
        end
        OP_ADD: begin
          acc_next = add_sum[WIDTH-1:0];
          cy_next  = add_sum[WIDTH];
        end
        OP_SUB: begin
          acc_next = sub_sum[WIDTH-1:0];
          cy_next  = sub_sum[WIDTH];
        end
        OP_CLEAR: begin
          acc_next = '0;
          cy_next  = 1'b0;
        end
        default: begin
          acc_next = acc_reg;
          cy_next  = cy_reg;
        end
      endcase
    end
  end

  // iclk_q resets high so a strobe already high through reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg    <= '0;
      cy_reg     <= 1'b0;
      iclk_q_reg <= 1'b1;
    end else begin
      acc_reg    <= acc_next;
      cy_reg     <= cy_next;
      iclk_q_reg <= bus.iclk;
    end
  end

  assign bus.s    = acc_reg;
  assign bus.cout = cy_reg;
endmodule

// File: tb/tb_addac_4.sv
// Bench for addac_4: a directed cycle table with fixed expectations, then random
// stimulus checked against an arithmetic reference model on every falling clk edge.
module tb_addac_4;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  addac_4_if #(.WIDTH(4)) bus_if ();

  addac_4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iclk;
    logic [1:0] sel;
    logic [3:0] a;
    logic [3:0] es;
    logic       ec;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: plain integers, updated from the operation rules.
  int m_acc;
  int m_cy;
  int m_prev;

  function automatic vec_t mk(input logic r, input logic i, input logic [1:0] sl,
                              input logic [3:0] av, input logic [3:0] es, input logic ec);
    vec_t v;
    v.rst = r; v.iclk = i; v.sel = sl; v.a = av; v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic drive(input logic r, input logic i, input logic [1:0] sl, input logic [3:0] av);
    rst         = r;
    bus_if.iclk = i;
    bus_if.sel1 = sl[1];
    bus_if.sel0 = sl[0];
    bus_if.a    = av;
  endtask

  // Advance the model with the inputs that will be present at the next rising edge.
  task automatic model_step();
    int av;
    int op;
    av = int'(bus_if.a);
    op = int'({bus_if.sel1, bus_if.sel0});
    if (rst == 1'b0) begin
      m_acc = 0; m_cy = 0; m_prev = 1;
    end else begin
      if (bus_if.iclk == 1'b1 && m_prev == 0) begin
        if (op == 0) begin
          m_acc = av; m_cy = 0;
        end else if (op == 1) begin
          m_cy  = (m_acc + av >= 16) ? 1 : 0;
          m_acc = (m_acc + av) % 16;
        end else if (op == 2) begin
          m_cy  = (m_acc >= av) ? 1 : 0;
          m_acc = (m_acc - av + 16) % 16;
        end else begin
          m_acc = 0; m_cy = 0;
        end
      end
      m_prev = (bus_if.iclk == 1'b1) ? 1 : 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] es, input logic ec);
    total++;
    if (bus_if.s !== es || bus_if.cout !== ec) begin
      bad++;
      $display("FAIL %s: got s=%h cout=%b, want s=%h cout=%b", name, bus_if.s, bus_if.cout, es, ec);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_acc = 0; m_cy = 0; m_prev = 1;
    drive(1'b0, 1'b1, 2'b00, 4'h0);

    // reset with iclk held high, then release: nothing happens
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 1, 2'b01, 4'h3, 4'h0, 0));
    // LOAD 5, ADD 3
    tbl.push_back(mk(1, 0, 2'b00, 4'h5, 4'h0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'h5, 4'h5, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'h3, 4'h5, 0));
    tbl.push_back(mk(1, 1, 2'b01, 4'h3, 4'h8, 0));
    // LOAD F, ADD 1 overflow, hold iclk high with changing inputs
    tbl.push_back(mk(1, 0, 2'b00, 4'hF, 4'h8, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'hF, 4'hF, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'h1, 4'hF, 0));
    tbl.push_back(mk(1, 1, 2'b01, 4'h1, 4'h0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 1, 2'(k % 4), 4'(k + 7), 4'h0, 1));
    // LOAD 9, SUB 4, SUB 7 (borrow)
    tbl.push_back(mk(1, 0, 2'b00, 4'h9, 4'h0, 1));
    tbl.push_back(mk(1, 1, 2'b00, 4'h9, 4'h9, 0));
    tbl.push_back(mk(1, 0, 2'b10, 4'h4, 4'h9, 0));
    tbl.push_back(mk(1, 1, 2'b10, 4'h4, 4'h5, 1));
    tbl.push_back(mk(1, 0, 2'b10, 4'h7, 4'h5, 1));
    tbl.push_back(mk(1, 1, 2'b10, 4'h7, 4'hE, 0));
    // SUB x-x, then 0-1
    tbl.push_back(mk(1, 0, 2'b10, 4'hE, 4'hE, 0));
    tbl.push_back(mk(1, 1, 2'b10, 4'hE, 4'h0, 1));
    tbl.push_back(mk(1, 0, 2'b10, 4'h1, 4'h0, 1));
    tbl.push_back(mk(1, 1, 2'b10, 4'h1, 4'hF, 0));
    // LOAD A, CLEAR, then inputs change with iclk low
    tbl.push_back(mk(1, 0, 2'b00, 4'hA, 4'hF, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'hA, 4'hA, 0));
    tbl.push_back(mk(1, 0, 2'b11, 4'h4, 4'hA, 0));
    tbl.push_back(mk(1, 1, 2'b11, 4'h4, 4'h0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'h3, 4'h0, 0));
    tbl.push_back(mk(1, 0, 2'b10, 4'h9, 4'h0, 0));
    // LOAD 6, then reset coinciding with an ADD strobe; a fresh edge is needed afterwards
    tbl.push_back(mk(1, 0, 2'b00, 4'h6, 4'h0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'h6, 4'h6, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'h2, 4'h6, 0));
    tbl.push_back(mk(0, 1, 2'b01, 4'h2, 4'h0, 0));
    tbl.push_back(mk(1, 1, 2'b01, 4'h2, 4'h0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4'h2, 4'h0, 0));
    tbl.push_back(mk(1, 1, 2'b01, 4'h2, 4'h2, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].iclk, tbl[k].sel, tbl[k].a);
      tick();
      check($sformatf("vec%0d", k), tbl[k].es, tbl[k].ec);
    end

    // Randomized phase checked against the model
    for (int n = 0; n < 400; n++) begin
      logic r;
      logic i;
      r = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      i = ($urandom_range(0, 2) == 0) ? ~bus_if.iclk : bus_if.iclk;
      drive(r, i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      tick();
      check($sformatf("rnd%0d", n), 4'(m_acc), m_cy[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
